// File: rtl/modbus_pkg.sv
// Shared definitions for the MODBUS serial front end: parity modes, receiver
// FSM states and a parity check helper.
package modbus_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // True when the received parity bit agrees with the data under the given mode.
  function automatic logic parity_ok(input logic [7:0] data, input logic pbit, input int mode);
    logic x;
    x = (^data) ^ pbit;
    return (mode == PARITY_ODD) ? x : ~x;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Free-running 16x oversample tick plus a bit-period tick every 16 sample ticks.
// Never re-phased, so it can be shared with a transmitter.
module baud_tick #(
  parameter int DIVW = 16,
  parameter int DIV  = 52
) (
  input  logic clk,
  input  logic reset,
  output logic stick_o,
  output logic bit_tick_o
);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  logic [DIVW-1:0] div_q, div_d;
  logic [3:0]      cnt_q, cnt_d;

  always_comb begin
    div_d = stick_o ? '0 : div_q + 1'b1;
    cnt_d = stick_o ? cnt_q + 4'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign stick_o    = (div_q == DIV_LAST);
  assign bit_tick_o = stick_o && (cnt_q == 4'hF);

endmodule

// File: rtl/modbus_uart_rx.sv
// 16x oversampling UART receiver (8 data bits, optional parity, 1 stop bit)
// producing ready/rxerr pulses and a bit-period tick for the MODBUS endpoint.
module modbus_uart_rx
  import modbus_pkg::*;
#(
  parameter int DIVW   = 16,
  parameter int DIV    = 52,
  parameter int PARITY = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       ready,
  output logic       rxerr,
  output logic       rxbusy,
  output logic       bit_tick
);

  logic       stick;
  logic       rx_meta_q, rx_s_q;
  rx_state_e  state_q, state_d;
  logic [3:0] ph_q, ph_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic       perr_q, perr_d;
  logic       ready_q, ready_d;
  logic       rxerr_q, rxerr_d;
  logic       busy_q, busy_d;

  baud_tick #(
    .DIVW(DIVW),
    .DIV (DIV)
  ) u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .stick_o   (stick),
    .bit_tick_o(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    rxerr_d = 1'b0;
    if (stick) begin
      if (state_q != ST_IDLE) ph_d = ph_q + 4'd1;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            ph_d    = 4'd0;
            busy_d  = 1'b1;
            perr_d  = 1'b0;
          end
        end
        ST_START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (ph_q == 4'd7 && rx_s_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (ph_q == 4'd15) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          if (ph_q == 4'd7) shift_d = {rx_s_q, shift_q[7:1]};
          if (ph_q == 4'd15) begin
            if (idx_q == 3'd7) state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            else               idx_d   = idx_q + 3'd1;
          end
        end
        ST_PARITY: begin
          if (ph_q == 4'd7)  perr_d  = ~parity_ok(shift_q, rx_s_q, PARITY);
          if (ph_q == 4'd15) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (ph_q == 4'd7) begin
            busy_d = 1'b0;
            if (!rx_s_q) begin
              rxerr_d = 1'b1;
              state_d = ST_WAIT_HIGH;
            end else if (perr_q) begin
              rxerr_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              dout_d  = shift_q;
              ready_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // Break or stuck-low line: wait for idle so only one error is reported.
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      ready_q   <= 1'b0;
      rxerr_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      ready_q   <= ready_d;
      rxerr_q   <= rxerr_d;
      busy_q    <= busy_d;
    end
  end

  assign dout   = dout_q;
  assign ready  = ready_q;
  assign rxerr  = rxerr_q;
  assign rxbusy = busy_q;

endmodule

// File: doc/modbus_uart_rx.md
Name: modbus_uart_rx

Overview:
- Serial receive front end feeding the MODBUS slave endpoint.
- Oversamples the RS-485/UART line at 16x and deframes 8-bit characters with optional parity.
- Produces the endpoint's `ready`/`rxerr`/`din` inputs, plus a free-running bit-period tick used as the endpoint's `timeout_clk`.

Parameters:
- DIVW, 16: width of the baud divider counter.
- DIV, 52: clk cycles per 1/16 bit (16 MHz / (16*19200)); minimum 2.
- PARITY, 2: 0 = none, 1 = odd, 2 = even (MODBUS RTU default even).

Ports:
- clk  in  1  reference clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  raw serial line, idle high, asynchronous to clk
- dout  out  8  last received character, LSB first on the wire
- ready  out  1  one-clk pulse: new good character in `dout`
- rxerr  out  1  one-clk pulse: parity or framing error
- rxbusy  out  1  high from start-bit detection until stop-bit sample
- bit_tick  out  1  one-clk pulse every 16 sample ticks, free running; drives the endpoint's `timeout_clk`

Behaviour:
- Reset: one clock (`clk`); reset is asynchronous and active-high; ports named `clk`, `reset` as in the codebase.
  - While `reset` is asserted: `dout`=0, `ready`=0, `rxerr`=0, `rxbusy`=0, `bit_tick`=0.
  - FSM to IDLE; divider and sample counters to 0; synchronizer flops to 1.
- Input synchronizer: `rx` passes through 2 flops into `rx_s`. All logic uses `rx_s` only.
- Sample tick:
  - Divider counts 0..DIV-1; `stick` pulses when it wraps.
  - Divider runs continuously and is never re-phased by start bits.
  - Edge uncertainty is at most 1/16 bit (accepted).
- `bit_tick`: a 4-bit counter of `stick` runs continuously; `bit_tick` pulses on the `stick` where the counter wraps 15->0.
- Character timing: sample phase counter `ph` (0..15) is cleared at start detection.
  - Mid-bit sample at ph==7; bit boundary at ph==15.
- FSM states:
  - IDLE: on `stick` with `rx_s`==0 -> START, ph=0, `rxbusy`=1.
  - START: at ph==7, if `rx_s`==1 -> false start, back to IDLE, `rxbusy`=0, no pulse. Otherwise continue; at ph==15 -> DATA, bit index 0.
  - DATA: at ph==7, shift `rx_s` into shift register LSB first. After bit 7's boundary -> PARITY, or STOP if PARITY==0.
  - PARITY: at ph==7, capture parity bit. Even: XOR of data and parity bit must be 0. Odd: must be 1. Mismatch sets internal `perr`. At boundary -> STOP.
  - STOP: at ph==7, `rxbusy`=0.
    - `rx_s`==1 and no `perr`: `dout` <= shift register, `ready` pulses 1 clk -> IDLE.
    - `rx_s`==0 (framing error / break): `rxerr` pulses -> WAIT_HIGH.
    - `perr` with good stop: `rxerr` pulses -> IDLE.
    - `dout` is not updated on any error.
  - WAIT_HIGH: stays until `rx_s`==1 on a `stick`, then -> IDLE. A held-low line yields exactly one `rxerr`.
- Exclusivity: `ready` and `rxerr` are never high together; each is high exactly one clk per character.
- Latency: `ready` rises 2 clk (synchronizer) + ≤1 `stick` after the stop-bit mid-sample point.
- Asynchronous `reset` mid-character abandons it with no pulse. The next character requires a fresh falling edge.
- Only 1 stop bit is checked; extra stop bits are treated as idle.

Decomposition:
- Shared package `modbus_pkg`: PARITY encodings (NONE=0, ODD=1, EVEN=2) and the FSM state localparams.
- One natural sub-module, `baud_tick`: divider plus 16-count, outputs `stick` and `bit_tick`. Reusable by the planned UART TX stage.
- Deframing FSM stays in `modbus_uart_rx`.

Test Plan (DIV=4, bit = 64 clk):
- 0xA5, even parity bit 0, stop 1 -> single `ready` pulse, `dout`=0xA5, `rxerr` never high.
- 0xA5 with parity bit 1 (even) -> one `rxerr` pulse, `dout` keeps previous value 0xA5 from prior frame, no `ready`.
- 0x3C with stop bit 0, then line held low 10 bit times -> exactly one `rxerr`. The next valid 0x11 after line high yields `ready` with `dout`=0x11.
- 20-clk low glitch on idle line -> no `ready`/`rxerr`; `rxbusy` pulses high then returns 0 by ph 7.
- `reset` asserted during bit 4 of 0xFF, then released -> outputs 0 immediately; next byte 0x03 received correctly.
- PARITY=0, back-to-back 0x01,0x03 with no idle gap -> two `ready` pulses 640 clk apart ±16; `bit_tick` period exactly 64 clk throughout.
